light_sequencer: RTL and testbench
==================================

Name: light_sequencer

Overview:
- Timed sequencer that generates the 3-bit pattern code driving the team's 6-lamp light decoder. It replaces static switch inputs with an automatically stepped code.
- Steps the code up or down at a programmable rate, once or in a continuous loop, with pause and abort.
- Sits between user controls (buttons/switches) and the combinational lamp decoder; its code output connects directly to the decoder's 3-bit input.

Parameters:
- DIV, 4, clock cycles per code step; legal range 1..255 (prescaler counter is 8 bits).
- LAST, 7, highest code value in the sequence; legal range 1..7.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; begins a sequence when sampled high in IDLE.
- dir  input  1  0 = count up (0→LAST), 1 = count down (LAST→0); latched on start.
- loop  input  1  1 = wrap at sequence end; sampled live at each end-of-sequence step.
- pause  input  1  level; freezes prescaler and code while high.
- abort  input  1  level; terminates any active sequence.
- code  output  3  pattern code to the lamp decoder (registered).
- busy  output  1  high in RUN and PAUSE (registered).
- done  output  1  one-cycle pulse on normal sequence completion (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; code = 0; busy = 0; done = 0; prescaler cnt = 0; dir_q = 0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- IDLE:
  - code holds its last value.
  - start = 1 → RUN. On the same edge: dir_q = dir; code = 0 if dir = 0, LAST if dir = 1; cnt = 0; busy = 1.
  - Latency: start sampled at edge N → busy and the start code are visible after edge N; the first step occurs at edge N+DIV.
- RUN, when pause = 0 and abort = 0:
  - cnt increments every cycle.
  - When cnt == DIV-1, a step occurs and cnt returns to 0.
  - Step, not at end: code = code+1 (up) or code−1 (down).
  - Step at end (code == LAST going up, or code == 0 going down):
    - loop = 1 → code wraps to its start value (0 up, LAST down); stay in RUN.
    - loop = 0 → DONE; code holds its end value.
  - DIV = 1: a step occurs every cycle.
- Pause:
  - pause = 1 in RUN → PAUSE on that edge; cnt and code do not advance on that edge.
  - PAUSE holds cnt and code while pause = 1; busy stays 1.
  - pause = 0 → RUN, and the count resumes from the held cnt. Total step period is DIV active cycles, excluding paused cycles.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle.
  - Next edge → IDLE, done = 0, regardless of inputs. start during DONE is ignored.
- Abort:
  - abort = 1 in RUN or PAUSE → IDLE on the next edge: code = 0, cnt = 0, busy = 0, no done pulse.
  - Abort has priority over pause, step and end detection.
  - abort in IDLE or DONE has no effect.
- start while in RUN or PAUSE is ignored. dir changes after start are ignored until the next start.
- Simultaneous start + abort in IDLE: start wins, since abort has no effect in IDLE.
- code always stays within 0..LAST; no out-of-range value is ever produced.

Test Plan (DIV = 4, LAST = 7):
- Reset, then one-shot up: pulse start with dir = 0, loop = 0 → code = 0,1,…,7, each held 4 cycles; done pulses 1 cycle at the step after 7; busy high for 32 cycles; code stays 7 in IDLE.
- Down with loop: start with dir = 1, loop = 1 → code = 7,6,…,0,7,6…, with no done. Drop loop while code = 3 → continues to 0, then done pulses once.
- Pause: in RUN at code = 2 with cnt = 1, hold pause for 10 cycles → code stays 2 for 10 + 4 cycles in total, then steps to 3.
- Abort: abort at code = 5 in RUN, and separately in PAUSE → next cycle code = 0, busy = 0, done never asserted.
- Start ignored while busy: pulse start at code = 4 → sequence timing unchanged. Change dir mid-run → direction unchanged.
- Asynchronous reset mid-sequence: drop rst_n between clock edges at code = 6 → code, busy and done go to 0 immediately, without waiting for a clock edge. After release, state is IDLE until the next start. Also repeat the one-shot up scenario with DIV = 1: code = 0..7 on consecutive cycles.

Source files
------------

// File: rtl/light_sequencer_if.sv
// Control/status bundle between user controls and the light sequencer.
// The master side drives the controls; the sequencer (slave) returns code/busy/done.
interface light_sequencer_if;
    logic       start;
    logic       dir;
    logic       loop;
    logic       pause;
    logic       abort;
    logic [2:0] code;
    logic       busy;
    logic       done;

    modport master (output start, dir, loop, pause, abort, input code, busy, done);
    modport slave  (input start, dir, loop, pause, abort, output code, busy, done);
endinterface

// File: rtl/light_sequencer.sv
// Timed sequencer stepping the 3-bit lamp pattern code up or down every DIV
// active cycles, once or looping, with pause and abort.
module light_sequencer #(
    parameter int unsigned DIV  = 4,
    parameter int unsigned LAST = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    light_sequencer_if.slave  sif
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [2:0] LAST_C = 3'(LAST);
    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] code_q, code_n;
    logic       dir_q, dir_n;
    logic       busy_q, busy_n;
    logic       done_q, done_n;

    logic       at_end;
    logic [2:0] start_code;
    logic [2:0] step_code;

    assign at_end     = dir_q ? (code_q == 3'd0) : (code_q == LAST_C);
    assign start_code = dir_q ? LAST_C : 3'd0;
    assign step_code  = dir_q ? (code_q - 3'd1) : (code_q + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= 8'd0;
            code_q <= 3'd0;
            dir_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            code_q <= code_n;
            dir_q  <= dir_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code_q;
        dir_n   = dir_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (sif.start) begin
                    state_n = S_RUN;
                    dir_n   = sif.dir;
                    code_n  = sif.dir ? LAST_C : 3'd0;
                    cnt_n   = 8'd0;
                    busy_n  = 1'b1;
                end
            end
            // The cycle that releases PAUSE counts as active, so paused cycles
            // are simply excluded from the DIV-cycle step period.
            S_RUN, S_PAUSE: begin
                if (sif.abort) begin
                    state_n = S_IDLE;
                    code_n  = 3'd0;
                    cnt_n   = 8'd0;
                    busy_n  = 1'b0;
                end else if (sif.pause) begin
                    state_n = S_PAUSE;
                end else begin
                    state_n = S_RUN;
                    if (cnt == DIV_M1) begin
                        cnt_n = 8'd0;
                        if (!at_end) begin
                            code_n = step_code;
                        end else if (sif.loop) begin
                            code_n = start_code;
                        end else begin
                            state_n = S_DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign sif.code = code_q;
    assign sif.busy = busy_q;
    assign sif.done = done_q;
endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench: a sequence-position model predicts code/busy/done for a
// DIV=4 and a DIV=1 sequencer driven by the same directed and random controls.
module tb_light_sequencer;
    localparam int LAST = 7;

    logic clk = 1'b0;
    logic rst_n;
    logic start, dir, loop, pause, abort;

    always #5 clk = ~clk;

    light_sequencer_if if4 ();
    light_sequencer_if if1 ();

    assign if4.start = start;  assign if1.start = start;
    assign if4.dir   = dir;    assign if1.dir   = dir;
    assign if4.loop  = loop;   assign if1.loop  = loop;
    assign if4.pause = pause;  assign if1.pause = pause;
    assign if4.abort = abort;  assign if1.abort = abort;

    light_sequencer #(.DIV(4), .LAST(LAST)) dut4 (.clk(clk), .rst_n(rst_n), .sif(if4));
    light_sequencer #(.DIV(1), .LAST(LAST)) dut1 (.clk(clk), .rst_n(rst_n), .sif(if1));

    typedef struct packed {
        logic [2:0] code;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        bit running;
        bit done_ph;
        bit down;
        int pos;      // steps taken along the sequence, 0..LAST
        int elapsed;  // active cycles spent at the current position
        int code;
    } mstate_t;

    mstate_t ms [2];
    exp_t    q4 [$];
    exp_t    q1 [$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      cycle = 0;

    function automatic mstate_t mstep(mstate_t s, int div, bit st, bit dr, bit lp, bit ps, bit ab);
        mstate_t n = s;
        n.done_ph = 1'b0;
        if (s.done_ph) return n;
        if (!s.running) begin
            if (st) begin
                n.running = 1'b1;
                n.down    = dr;
                n.pos     = 0;
                n.elapsed = 0;
                n.code    = dr ? LAST : 0;
            end
        end else if (ab) begin
            n.running = 1'b0;
            n.code    = 0;
        end else if (!ps) begin
            n.elapsed = s.elapsed + 1;
            if (n.elapsed == div) begin
                n.elapsed = 0;
                if (s.pos == LAST) begin
                    if (lp) n.pos = 0;
                    else begin
                        n.running = 1'b0;
                        n.done_ph = 1'b1;
                    end
                end else begin
                    n.pos = s.pos + 1;
                end
                n.code = n.down ? LAST - n.pos : n.pos;
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(mstate_t s);
        exp_t e;
        e.code = 3'(s.code);
        e.busy = s.running;
        e.done = s.done_ph;
        return e;
    endfunction

    // Reference model: advances on every clock edge, resets asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) ms[k] = '{default: 0};
            q4.delete();
            q1.delete();
            q4.push_back(to_exp(ms[0]));
            q1.push_back(to_exp(ms[1]));
        end else begin
            ms[0] = mstep(ms[0], 4, start, dir, loop, pause, abort);
            ms[1] = mstep(ms[1], 1, start, dir, loop, pause, abort);
            q4.push_back(to_exp(ms[0]));
            q1.push_back(to_exp(ms[1]));
        end
    end

    task automatic cmp(string name, exp_t act, exp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d act code=%0d busy=%b done=%b exp code=%0d busy=%b done=%b",
                     name, cycle, act.code, act.busy, act.done, exp.code, exp.busy, exp.done);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare away from the active edge.
    always @(negedge clk) begin
        exp_t e, a;
        cycle++;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            a = '{code: if4.code, busy: if4.busy, done: if4.done};
            cmp("div4", a, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = '{code: if1.code, busy: if1.busy, done: if1.done};
            cmp("div1", a, e);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(bit d, bit l);
        dir = d; loop = l; start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        exp_t zero;
        zero = '0;
        rst_n = 1'b0;
        start = 0; dir = 0; loop = 0; pause = 0; abort = 0;
        cyc(3);
        #3 rst_n = 1'b1;
        cyc(2);

        // one-shot up, then idle holding 7
        pulse_start(1'b0, 1'b0);
        cyc(40);

        // down with loop, then drop loop at code 3
        pulse_start(1'b1, 1'b1);
        cyc(40);
        for (int i = 0; i < 200 && ms[0].code != 3; i++) cyc(1);
        loop = 1'b0;
        cyc(40);

        // pause for 10 cycles at code 2 with cnt 1
        pulse_start(1'b0, 1'b0);
        cyc(9);
        pause = 1'b1;
        cyc(10);
        pause = 1'b0;
        cyc(45);

        // abort in RUN at code 5
        pulse_start(1'b0, 1'b0);
        cyc(21);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        cyc(5);

        // abort in PAUSE
        pulse_start(1'b0, 1'b0);
        cyc(5);
        pause = 1'b1;
        cyc(3);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0; pause = 1'b0;
        cyc(5);

        // start and dir changes while busy are ignored
        pulse_start(1'b0, 1'b0);
        cyc(17);
        start = 1'b1; dir = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(20);

        // asynchronous reset mid-sequence at code 6
        pulse_start(1'b0, 1'b1);
        cyc(25);
        #3 rst_n = 1'b0;
        #1;
        cmp("async_rst_div4", '{code: if4.code, busy: if4.busy, done: if4.done}, zero);
        cmp("async_rst_div1", '{code: if1.code, busy: if1.busy, done: if1.done}, zero);
        cyc(2);
        #3 rst_n = 1'b1;
        cyc(6);

        // random controls
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 7) == 0);
            dir   = $urandom_range(0, 1) == 1;
            loop  = ($urandom_range(0, 3) != 0);
            pause = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 39) == 0);
            cyc(1);
        end
        start = 0; pause = 0; abort = 0; loop = 0;
        cyc(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
